// File: rtl/filter_scratch_pkg.sv
// Purpose: shared widths, index type and address composition for the filter scratch ring.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package filter_scratch_pkg;

    // Plain-integer slot/element index used for address arithmetic before truncation.
    typedef int unsigned slot_idx_t;

    // clog2 with a floor of 1 so single-entry dimensions still get a 1-bit field.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Flat RAM address of word `elem` inside filter slot `slot`.
    function automatic slot_idx_t compose_addr(input slot_idx_t slot,
                                               input slot_idx_t elem,
                                               input slot_idx_t size);
        return slot * size + elem;
    endfunction

endpackage

// File: rtl/filter_scratch_mem.sv
// Purpose: 1R1W synchronous RAM holding all filter slots, read-before-write.
// Latency: 1 cycle read (rd_dat registered); writes land at the clock edge.
// Backpressure: none; accepts one read and one write every cycle.
//
// Ports: clk/rst (sync, active-high, clears only the read register), wr_en/wr_addr/wr_dat,
//        rd_en/rd_addr (rd_clr forces a zero load instead of RAM data), rd_dat.
module filter_scratch_mem #(
    parameter int WIDTH = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic             rd_clr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic             wr_hit, rd_hit;
    logic [IW-1:0]    wr_idx, rd_idx;

    // Addresses past the populated depth are ignored on write and read back as zero.
    assign wr_hit = int'(wr_addr) < DEPTH;
    assign rd_hit = int'(rd_addr) < DEPTH;
    assign wr_idx = wr_addr[IW-1:0];
    assign rd_idx = rd_addr[IW-1:0];

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            if (rd_clr || !rd_hit) begin
                rd_dat_d = '0;
            end else begin
                rd_dat_d = ram[rd_idx];
            end
        end
    end

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_hit) begin
            ram[wr_idx] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/filter_scratch_ring.sv
// Purpose: ring of FILTER_NUMS filter slots; loads filters sequentially, reads relative to oldest.
// Latency: write accepted same cycle; read data 1 cycle after rd_en; filters_valid 1 cycle after last word.
// Backpressure: wr_ready low while all slots hold complete filters; reads are never stalled.
//
// Ports: clk, rst (sync active-high), chip_en (low freezes everything),
//        wr_valid/wr_ready/din (write port), rd_en/rd_slot/rd_elem -> dout (registered),
//        release_req (frees the oldest complete filter), filters_valid, last_write, rd_err.
// Build option: FILTER_SCRATCH_OOB_CHECK_EN enables out-of-range read detection (rd_err);
//               without it reads wrap modulo the ring and rd_err is tied low.
module filter_scratch_ring
    import filter_scratch_pkg::*;
#(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 8,
    parameter int FILTER_NUMS          = 4,
    parameter int FILTER_SIZE          = 9,
    parameter int SW                   = clog2_min1(FILTER_NUMS),
    parameter int EW                   = clog2_min1(FILTER_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            chip_en,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [SCRATCH_WIDTH-1:0]        din,
    input  logic                            rd_en,
    input  logic [SW-1:0]                   rd_slot,
    input  logic [EW-1:0]                   rd_elem,
    output logic [SCRATCH_WIDTH-1:0]        dout,
    input  logic                            release_req,
    output logic [SW:0]                     filters_valid,
    output logic [SCRATCH_ADDRESS_SIZE-1:0] last_write,
    output logic                            rd_err
);
    localparam int CW    = SW + 1;
    localparam int AW    = SCRATCH_ADDRESS_SIZE;
    localparam int DEPTH = FILTER_NUMS * FILTER_SIZE;

    logic [SW-1:0] wr_slot_q, wr_slot_d;
    logic [SW-1:0] head_slot_q, head_slot_d;
    logic [EW-1:0] wr_elem_q, wr_elem_d;
    logic [CW-1:0] count_q, count_d;

    logic          wr_acc, wr_last, rel_ok, rd_clr;
    logic [CW-1:0] rd_slot_red, rd_phys_sum;
    logic [SW-1:0] rd_phys;
    logic [AW-1:0] rd_addr, wr_addr;

    assign wr_ready = count_q < CW'(FILTER_NUMS);
    assign wr_acc   = chip_en & wr_valid & wr_ready;
    assign wr_last  = wr_elem_q == EW'(FILTER_SIZE - 1);
    assign rel_ok   = chip_en & release_req & (count_q != '0);

    // Completion and release in the same cycle cancel on count but both pointers move.
    always_comb begin
        wr_slot_d   = wr_slot_q;
        wr_elem_d   = wr_elem_q;
        head_slot_d = head_slot_q;
        count_d     = count_q;
        if (wr_acc) begin
            if (wr_last) begin
                wr_elem_d = '0;
                wr_slot_d = (wr_slot_q == SW'(FILTER_NUMS - 1)) ? '0 : wr_slot_q + SW'(1);
                count_d   = count_d + CW'(1);
            end else begin
                wr_elem_d = wr_elem_q + EW'(1);
            end
        end
        if (rel_ok) begin
            head_slot_d = (head_slot_q == SW'(FILTER_NUMS - 1)) ? '0 : head_slot_q + SW'(1);
            count_d     = count_d - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_slot_q   <= '0;
            wr_elem_q   <= '0;
            head_slot_q <= '0;
            count_q     <= '0;
        end else begin
            wr_slot_q   <= wr_slot_d;
            wr_elem_q   <= wr_elem_d;
            head_slot_q <= head_slot_d;
            count_q     <= count_d;
        end
    end

    // Modulo without a divider: rd_slot < 2^SW < 2*FILTER_NUMS, so one conditional
    // subtract brings it in range, and head + reduced offset needs one more.
    always_comb begin
        rd_slot_red = ({1'b0, rd_slot} >= CW'(FILTER_NUMS)) ?
                      {1'b0, rd_slot} - CW'(FILTER_NUMS) : {1'b0, rd_slot};
        rd_phys_sum = {1'b0, head_slot_q} + rd_slot_red;
        rd_phys     = (rd_phys_sum >= CW'(FILTER_NUMS)) ?
                      SW'(rd_phys_sum - CW'(FILTER_NUMS)) : rd_phys_sum[SW-1:0];
    end

    assign rd_addr = AW'(compose_addr(slot_idx_t'(rd_phys), slot_idx_t'(rd_elem),
                                      slot_idx_t'(FILTER_SIZE)));
    assign wr_addr = AW'(compose_addr(slot_idx_t'(wr_slot_q), slot_idx_t'(wr_elem_q),
                                      slot_idx_t'(FILTER_SIZE)));

`ifdef FILTER_SCRATCH_OOB_CHECK_EN
    logic rd_oob;
    logic rd_err_q, rd_err_d;

    // Offsets beyond the complete filters, or words past the filter end, return zero.
    assign rd_oob = ({1'b0, rd_slot} >= count_q) || (int'(rd_elem) >= FILTER_SIZE);

    always_comb begin
        rd_err_d = rd_err_q;
        if (chip_en && rd_en) begin
            rd_err_d = rd_oob;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_clr = rd_oob;
    assign rd_err = rd_err_q;
`else
    assign rd_clr = 1'b0;
    assign rd_err = 1'b0;
`endif

    filter_scratch_mem #(
        .WIDTH (SCRATCH_WIDTH),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_addr),
        .wr_dat  (din),
        .rd_en   (chip_en & rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (rd_addr),
        .rd_dat  (dout)
    );

    assign filters_valid = count_q;
    assign last_write    = wr_addr;

endmodule

// File: tb/tb_filter_scratch_ring.sv
// Purpose: self-checking bench for filter_scratch_ring (directed table, corner sequences, random).
// Latency: n/a.
// Backpressure: n/a.
module tb_filter_scratch_ring;
    localparam int N = 4;
    localparam int S = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       chip_en;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] din;
    logic       rd_en;
    logic [1:0] rd_slot;
    logic [3:0] rd_elem;
    logic [7:0] dout;
    logic       release_req;
    logic [2:0] filters_valid;
    logic [7:0] last_write;
    logic       rd_err;

    filter_scratch_ring dut (
        .clk           (clk),
        .rst           (rst),
        .chip_en       (chip_en),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .din           (din),
        .rd_en         (rd_en),
        .rd_slot       (rd_slot),
        .rd_elem       (rd_elem),
        .dout          (dout),
        .release_req   (release_req),
        .filters_valid (filters_valid),
        .last_write    (last_write),
        .rd_err        (rd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: linear write position over the whole ring, head slot, count,
    // a word-addressed memory image with "known" flags for never-written words.
    int m_pos, m_head, m_count, m_dout, m_err;
    bit m_dout_known;
    int m_mem   [256];
    bit m_known [256];

`ifdef FILTER_SCRATCH_OOB_CHECK_EN
    localparam bit OOB = 1'b1;
`else
    localparam bit OOB = 1'b0;
`endif

    typedef struct {
        bit wv; int d; bit re; int rs; int ri; bit rl;
        int fv; int rdy; int lw; int dout;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("fv", int'(filters_valid), m_count);
        chk("rdy", int'(wr_ready), (m_count < N) ? 1 : 0);
        chk("lw", int'(last_write), m_pos);
        chk("err", int'(rd_err), m_err);
        if (m_dout_known) chk("dout", int'(dout), m_dout);
    endtask

    task automatic do_reset();
        rst = 1'b1; chip_en = 1'b1; wr_valid = 1'b0; din = '0; rd_en = 1'b0;
        rd_slot = '0; rd_elem = '0; release_req = 1'b0;
        @(posedge clk); #1;
        m_pos = 0; m_head = 0; m_count = 0; m_dout = 0; m_err = 0; m_dout_known = 1'b1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_fv", int'(filters_valid), 0);
        chk("rst_rdy", int'(wr_ready), 1);
        chk("rst_lw", int'(last_write), 0);
        chk("rst_err", int'(rd_err), 0);
        rst = 1'b0;
    endtask

    task automatic cyc(input bit ce, input bit wv, input int d, input bit re,
                       input int rs, input int ri, input bit rl);
        int  addr;
        bit  oob, done, rdy;
        chip_en = ce; wr_valid = wv; din = 8'(d); rd_en = re;
        rd_slot = 2'(rs); rd_elem = 4'(ri); release_req = rl;
        done = 1'b0;
        rdy  = m_count < N;
        if (ce) begin
            if (re) begin
                addr = ((m_head + rs) % N) * S + ri;
                oob  = OOB && ((rs >= m_count) || (ri >= S));
                if (oob) begin
                    m_dout = 0; m_err = 1; m_dout_known = 1'b1;
                end else begin
                    m_err = 0;
                    if (addr < N * S) begin
                        m_dout = m_mem[addr]; m_dout_known = m_known[addr];
                    end else begin
                        m_dout = 0; m_dout_known = 1'b1;
                    end
                end
            end
            if (wv && rdy) begin
                m_mem[m_pos] = d & 8'hFF; m_known[m_pos] = 1'b1;
                m_pos = (m_pos + 1) % (N * S);
                done  = (m_pos % S) == 0;
            end
            if (rl && m_count > 0) begin
                m_head = (m_head + 1) % N;
                m_count--;
            end
            if (done) m_count++;
        end
        @(posedge clk); #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 0; m_known[i] = 1'b0;
        end
        rst = 1'b1; chip_en = 1'b0; wr_valid = 1'b0; din = '0; rd_en = 1'b0;
        rd_slot = '0; rd_elem = '0; release_req = 1'b0;

        // Directed table: load 0x01..0x09 into filter 0, then read it back.
        for (int i = 0; i < 9; i++)
            tbl[i] = '{1'b1, i + 1, 1'b0, 0, 0, 1'b0, (i == 8) ? 1 : 0, 1, i + 1, 0};
        tbl[9]  = '{1'b0, 0, 1'b1, 0, 4, 1'b0, 1, 1, 9, 5};
        tbl[10] = '{1'b0, 0, 1'b0, 0, 0, 1'b0, 1, 1, 9, 5};
        tbl[11] = '{1'b0, 0, 1'b1, 0, 8, 1'b0, 1, 1, 9, 9};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, tbl[i].wv, tbl[i].d, tbl[i].re, tbl[i].rs, tbl[i].ri, tbl[i].rl);
            chk("tbl_fv", int'(filters_valid), tbl[i].fv);
            chk("tbl_rdy", int'(wr_ready), tbl[i].rdy);
            chk("tbl_lw", int'(last_write), tbl[i].lw);
            chk("tbl_dout", int'(dout), tbl[i].dout);
        end

        // Fill the ring: backpressure, wrapped write address, release reopens it.
        for (int i = 0; i < 27; i++) cyc(1'b1, 1'b1, 'h10 + i, 1'b0, 0, 0, 1'b0);
        chk("full_rdy", int'(wr_ready), 0);
        chk("full_fv", int'(filters_valid), 4);
        chk("full_lw", int'(last_write), 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 'hEE, 1'b0, 0, 0, 1'b0);
            chk("ignored_lw", int'(last_write), 0);
            chk("ignored_fv", int'(filters_valid), 4);
        end
        cyc(1'b1, 1'b0, 0, 1'b1, 3, 0, 1'b0);
        chk("full_rd_slot3", int'(dout), 'h22);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        chk("rel_fv", int'(filters_valid), 3);
        chk("rel_rdy", int'(wr_ready), 1);
        cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1'b0);
        chk("rel_rd_head", int'(dout), 'h10);

        // Completion and release on the same edge with two filters held.
        do_reset();
        for (int i = 0; i < 26; i++) cyc(1'b1, 1'b1, 'h40 + i, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 'h40 + 26, 1'b0, 0, 0, 1'b1);
        chk("simul_fv", int'(filters_valid), 2);
        chk("simul_lw", int'(last_write), 27);
        cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1'b0);
        chk("simul_rd0", int'(dout), 'h49);
        cyc(1'b1, 1'b0, 0, 1'b1, 1, 0, 1'b0);
        chk("simul_rd1", int'(dout), 'h52);

        // Release with filters 0 and 1 held: offset 0 now names filter 1.
        do_reset();
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1, 'h60 + i, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        chk("rel1_fv", int'(filters_valid), 1);
        cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1'b0);
        chk("rel1_rd", int'(dout), 'h69);

        // Read past the held filters: zero + error with the check, raw wrapped RAM without.
        cyc(1'b1, 1'b0, 0, 1'b1, 1, 0, 1'b0);
        chk("oob_slot_dout", int'(dout), OOB ? 0 : 'h52);
        chk("oob_slot_err", int'(rd_err), OOB ? 1 : 0);
        cyc(1'b1, 1'b0, 0, 1'b1, 0, 2, 1'b0);
        chk("inrange_dout", int'(dout), 'h6B);
        chk("inrange_err", int'(rd_err), 0);
        if (OOB) begin
            cyc(1'b1, 1'b0, 0, 1'b1, 0, 9, 1'b0);
            chk("oob_elem_err", int'(rd_err), 1);
            cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1'b0);
            chk("oob_clear_err", int'(rd_err), 0);
        end

        // chip_en low freezes write, read, release and pointers.
        cyc(1'b0, 1'b1, 'h77, 1'b1, 0, 5, 1'b1);
        chk("ce_lw", int'(last_write), 18);
        chk("ce_fv", int'(filters_valid), 1);

        // Reset mid-load discards the partial filter; next load restarts at address 0.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 'h80 + i, 1'b0, 0, 0, 1'b0);
        do_reset();
        cyc(1'b1, 1'b1, 'hA5, 1'b0, 0, 0, 1'b0);
        chk("restart_lw", int'(last_write), 1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 'hB0 + i, 1'b0, 0, 0, 1'b0);
        chk("restart_fv", int'(filters_valid), 1);
        cyc(1'b1, 1'b0, 0, 1'b1, 0, 0, 1'b0);
        chk("restart_rd", int'(dout), 'hA5);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                    int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, OOB ? 15 : 8)),
                    $urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
